// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// frame-length helper used by the framer and its bench.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_EVEN = 1;
  localparam int unsigned PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int unsigned frame_bits(input int unsigned data_bits,
                                             input int unsigned parity_mode,
                                             input int unsigned stop_bits);
    return 1 + data_bits + ((parity_mode != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// pre_tick marks the clock before the terminal count so callers can register
// outputs that must line up with the last clock of a bit.
module uart_baud_tick #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic restart,
  output logic tick,
  output logic pre_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick     = (count == CNT_W'(CLKS_PER_BIT - 1));
  assign pre_tick = (count == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: one-word holding register in front of a start/data/
// parity/stop serialiser, LSB first, with back-to-back frames and no idle gap.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = PARITY_NONE,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_serial,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int unsigned BIT_W      = $clog2(DATA_BITS + 1);
  localparam int unsigned FRAME_BITS = frame_bits(DATA_BITS, PARITY_MODE, STOP_BITS);
  localparam logic        STOP_LAST  = 1'(STOP_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > PARITY_ODD ||
      STOP_BITS < 1 || STOP_BITS > 2 || CLKS_PER_BIT < 2 || FRAME_BITS > 13) begin : g_bad_params
    $error("uart_tx_frame: unsupported parameter set");
  end

  tx_state_t            state;
  logic [DATA_BITS-1:0] hold;
  logic [DATA_BITS-1:0] shifter;
  logic                 parity_bit;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 stop_cnt;
  logic                 hold_full;
  logic                 baud_restart;
  logic                 tick;
  logic                 pre_tick;

  // tx_ready is the registered inverse of the hold occupancy.
  assign hold_full = ~tx_ready;

  // Every non-IDLE state is entered on a tick, where the counter wraps to 0
  // anyway, so holding it cleared in IDLE restarts it on every state entry.
  assign baud_restart = (state == ST_IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clock    (clock),
    .reset_n  (reset_n),
    .restart  (baud_restart),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY_MODE == PARITY_ODD) ? ~^d : ^d;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      hold       <= '0;
      shifter    <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      tx_ready   <= 1'b1;
      tx_serial  <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      if (tx_valid && tx_ready) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          tx_serial <= 1'b1;
          if (hold_full) begin
            state      <= ST_START;
            shifter    <= hold;
            parity_bit <= parity_of(hold);
            tx_ready   <= 1'b1;
            tx_serial  <= 1'b0;
            busy       <= 1'b1;
          end
        end

        ST_START: begin
          if (tick) begin
            state     <= ST_DATA;
            bit_cnt   <= '0;
            tx_serial <= shifter[0];
          end
        end

        ST_DATA: begin
          if (tick) begin
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              stop_cnt <= 1'b0;
              if (PARITY_MODE != PARITY_NONE) begin
                state     <= ST_PARITY;
                tx_serial <= parity_bit;
              end else begin
                state     <= ST_STOP;
                tx_serial <= 1'b1;
              end
            end else begin
              shifter   <= shifter >> 1;
              tx_serial <= shifter[1];
              bit_cnt   <= bit_cnt + 1'b1;
            end
          end
        end

        ST_PARITY: begin
          if (tick) begin
            state     <= ST_STOP;
            stop_cnt  <= 1'b0;
            tx_serial <= 1'b1;
          end
        end

        ST_STOP: begin
          // Registered pulse must be visible during the final clock of the frame.
          if (pre_tick && stop_cnt == STOP_LAST) begin
            frame_done <= 1'b1;
          end
          if (tick) begin
            if (stop_cnt != STOP_LAST) begin
              stop_cnt <= 1'b1;
            end else if (hold_full) begin
              state      <= ST_START;
              shifter    <= hold;
              parity_bit <= parity_of(hold);
              tx_ready   <= 1'b1;
              tx_serial  <= 1'b0;
            end else begin
              state     <= ST_IDLE;
              tx_serial <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          tx_serial <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: three configurations (8E1, 8O1, 7N2) at 4 clocks per
// bit, checked against a frame-as-bit-vector reference model every clock.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int unsigned C  = 4;
  localparam int          NI = 3;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [2:0] valid;
  logic [8:0] data [NI];
  logic [2:0] ready, serial, busy, done;
  logic [2:0] ready_pre;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) ready_pre = ready;

  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(PARITY_EVEN), .STOP_BITS(1), .CLKS_PER_BIT(C)) dut_e (
    .clock(clock), .reset_n(reset_n), .tx_data(data[0]), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .tx_serial(serial[0]), .busy(busy[0]), .frame_done(done[0]));

  uart_tx_frame #(.DATA_BITS(8), .PARITY_MODE(PARITY_ODD), .STOP_BITS(1), .CLKS_PER_BIT(C)) dut_o (
    .clock(clock), .reset_n(reset_n), .tx_data(data[1]), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .tx_serial(serial[1]), .busy(busy[1]), .frame_done(done[1]));

  uart_tx_frame #(.DATA_BITS(7), .PARITY_MODE(PARITY_NONE), .STOP_BITS(2), .CLKS_PER_BIT(C)) dut_n (
    .clock(clock), .reset_n(reset_n), .tx_data(data[2][6:0]), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .tx_serial(serial[2]), .busy(busy[2]), .frame_done(done[2]));

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned db_of(input int i);
    return (i == 2) ? 7 : 8;
  endfunction
  function automatic int unsigned par_of(input int i);
    return (i == 0) ? PARITY_EVEN : (i == 1) ? PARITY_ODD : PARITY_NONE;
  endfunction
  function automatic int unsigned stop_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  // Line bits of one frame, index 0 = start bit.
  function automatic logic [15:0] build_frame(input int i, input logic [8:0] w);
    logic [15:0] v;
    int idx;
    int ones;
    v = '0;
    idx = 1;
    ones = 0;
    for (int b = 0; b < int'(db_of(i)); b++) begin
      v[idx] = w[b];
      ones += int'(w[b]);
      idx++;
    end
    if (par_of(i) != PARITY_NONE) begin
      v[idx] = (par_of(i) == PARITY_EVEN) ? 1'(ones % 2) : 1'(1 - ones % 2);
      idx++;
    end
    for (int s = 0; s < int'(stop_of(i)); s++) begin
      v[idx] = 1'b1;
      idx++;
    end
    return v;
  endfunction

  // Reference model: current frame as a bit vector plus a clock position.
  logic        m_active [NI];
  int          m_pos    [NI];
  int          m_len    [NI];
  logic [15:0] m_vec    [NI];
  logic        m_hfull  [NI];
  logic [8:0]  m_hword  [NI];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NI; i++) begin
        m_active[i] = 1'b0;
        m_pos[i]    = 0;
        m_len[i]    = 0;
        m_hfull[i]  = 1'b0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        logic acc;
        acc = valid[i] && !m_hfull[i];
        if (m_active[i]) begin
          m_pos[i]++;
          if (m_pos[i] == m_len[i]) m_active[i] = 1'b0;
        end
        if (!m_active[i] && m_hfull[i]) begin
          m_vec[i]    = build_frame(i, m_hword[i]);
          m_len[i]    = int'(frame_bits(db_of(i), par_of(i), stop_of(i)) * C);
          m_pos[i]    = 0;
          m_active[i] = 1'b1;
          m_hfull[i]  = 1'b0;
        end
        if (acc) begin
          m_hfull[i] = 1'b1;
          m_hword[i] = data[i];
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        logic exp_line;
        exp_line = m_active[i] ? m_vec[i][m_pos[i] / int'(C)] : 1'b1;
        check($sformatf("model_serial[%0d]", i), int'(serial[i]), int'(exp_line));
        check($sformatf("model_busy[%0d]", i), int'(busy[i]), int'(m_active[i]));
        check($sformatf("model_ready[%0d]", i), int'(ready[i]), int'(!m_hfull[i]));
        check($sformatf("model_done[%0d]", i), int'(done[i]),
              int'(m_active[i] && m_pos[i] == m_len[i] - 1));
      end
    end
  end

  typedef struct {
    int         sel;
    logic [8:0] word;
    logic [15:0] frame;
    int         nbits;
  } vec_t;

  vec_t tbl [8];

  task automatic wait_idle(input int s);
    int guard;
    guard = 0;
    while ((busy[s] || !ready[s]) && guard < 300) begin
      @(posedge clock); #1;
      guard++;
    end
    check("idle_wait", int'(guard < 300), 1);
  endtask

  task automatic send_and_check(input vec_t v);
    int s;
    int n_done;
    int done_at;
    s = v.sel;
    n_done = 0;
    done_at = -1;
    wait_idle(s);
    valid[s] = 1'b1;
    data[s]  = v.word;
    @(posedge clock); #1;
    valid[s] = 1'b0;
    check("ready_low_after_accept", int'(ready[s]), 0);
    @(posedge clock); #1;
    check("ready_back_after_1clk", int'(ready[s]), 1);
    for (int c = 0; c < v.nbits * int'(C) + 4; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      if (c % int'(C) == 1 && c / int'(C) < v.nbits)
        check($sformatf("frame_bit%0d_w%0h", c / int'(C), v.word), int'(serial[s]),
              int'(v.frame[c / int'(C)]));
      if (done[s]) begin
        n_done++;
        done_at = c;
      end
    end
    check("frame_done_count", n_done, 1);
    check("frame_done_clock", done_at + 1, v.nbits * int'(C));
  endtask

  initial begin
    int idle_done;
    int idle_low;
    int t_acc [3];
    int k;
    int guard;
    int busy_low;
    logic [8:0] words [3];

    tbl[0] = '{0, 9'h0A5, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11};
    tbl[1] = '{1, 9'h000, {5'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11};
    tbl[2] = '{2, 9'h07F, {6'b0, 2'b11, 7'h7F, 1'b0}, 10};
    tbl[3] = '{0, 9'h001, {5'b0, 1'b1, 1'b1, 8'h01, 1'b0}, 11};
    tbl[4] = '{1, 9'h0FF, {5'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11};
    tbl[5] = '{1, 9'h080, {5'b0, 1'b1, 1'b0, 8'h80, 1'b0}, 11};
    tbl[6] = '{2, 9'h02A, {6'b0, 2'b11, 7'h2A, 1'b0}, 10};
    tbl[7] = '{0, 9'h03C, {5'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11};

    valid = '0;
    for (int i = 0; i < NI; i++) data[i] = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("reset_serial", int'(serial[i]), 1);
      check("reset_ready", int'(ready[i]), 1);
      check("reset_busy", int'(busy[i]), 0);
      check("reset_done", int'(done[i]), 0);
    end
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    chk_en = 1'b1;

    // No traffic: line stays idle.
    idle_done = 0;
    idle_low = 0;
    repeat (50) begin
      @(posedge clock); #1;
      if (done != 3'b000) idle_done++;
      if (serial != 3'b111 || busy != 3'b000) idle_low++;
    end
    check("idle_frame_done_pulses", idle_done, 0);
    check("idle_line_activity", idle_low, 0);

    foreach (tbl[n]) send_and_check(tbl[n]);

    // Back-to-back: valid held high over three words.
    wait_idle(0);
    words[0] = 9'h011;
    words[1] = 9'h022;
    words[2] = 9'h033;
    k = 0;
    guard = 0;
    busy_low = 0;
    t_acc[0] = 0;
    t_acc[1] = 0;
    t_acc[2] = 0;
    valid[0] = 1'b1;
    data[0]  = words[0];
    while (k < 3 && guard < 300) begin
      @(posedge clock); #1;
      guard++;
      if (ready_pre[0]) begin
        t_acc[k] = cyc;
        k++;
        if (k < 3) data[0] = words[k];
        else valid[0] = 1'b0;
      end
      if (k >= 1 && !busy[0] && cyc > t_acc[0]) busy_low++;
      if (k >= 1 && cyc == t_acc[0] + 44) begin
        check("b2b_last_stop_high", int'(serial[0]), 1);
        check("b2b_done_on_last_stop", int'(done[0]), 1);
      end
      if (k >= 1 && cyc == t_acc[0] + 45)
        check("b2b_next_start_no_gap", int'(serial[0]), 0);
    end
    valid[0] = 1'b0;
    check("b2b_accept_count", k, 3);
    check("b2b_second_accept", t_acc[1] - t_acc[0], 2);
    check("b2b_third_accept", t_acc[2] - t_acc[0], 46);
    check("b2b_busy_gaps", busy_low, 0);

    // Asynchronous reset during data bit 3 (0xF7 has a 0 there).
    wait_idle(0);
    valid[0] = 1'b1;
    data[0]  = 9'h0F7;
    @(posedge clock); #1;
    valid[0] = 1'b0;
    @(posedge clock); #1;
    repeat (17) begin
      @(posedge clock); #1;
    end
    check("pre_reset_data_bit3", int'(serial[0]), 0);
    check("pre_reset_busy", int'(busy[0]), 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_serial", int'(serial[0]), 1);
    check("async_reset_busy", int'(busy[0]), 0);
    check("async_reset_ready", int'(ready[0]), 1);
    check("async_reset_done", int'(done[0]), 0);
    @(posedge clock); #1 reset_n = 1'b1;
    send_and_check(tbl[7]);

    // Random traffic on all three configurations.
    repeat (1500) begin
      @(posedge clock); #1;
      for (int i = 0; i < NI; i++) begin
        valid[i] = ($urandom_range(0, 3) != 0);
        data[i]  = 9'($urandom);
      end
    end
    valid = '0;
    repeat (150) begin
      @(posedge clock); #1;
    end
    for (int i = 0; i < NI; i++) begin
      check("drain_busy", int'(busy[i]), 0);
      check("drain_serial", int'(serial[i]), 1);
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
